mesif_snoop_bus_controller: RTL

- Sequential snoopy-bus controller for an N-cache MESIF system.
- Arbitrates cache bus requests and broadcasts each transaction as a snoop, then collects shared/supply/dirty responses.
- Serves reads by cache-to-cache intervention (F/M owner) or from RAM. Performs RAM writeback when a Modified owner supplies data.
- Sits between the per-cache bus masters and the single RAM port; the bus is held until RAM is consistent.

---
 rtl/mesif_snoop_bus_controller.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mesif_snoop_bus_controller.sv
// ============================================================================
// Module   : mesif_snoop_bus_controller
// Purpose  : Snoopy-bus arbiter and sequencer for an N-cache MESIF system.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesif_snoop_bus_controller #(
    parameter int ADDRESS_WIDTH     = 16,
    parameter int DATA_WIDTH        = 16,
    parameter int NUMBER_OF_DEVICES = 4,
    parameter int ARBITRATION_MODE  = 1,
    parameter int SNOOP_TIMEOUT     = 15
) (
    input  logic                                      clock_i,
    input  logic                                      reset_i,
    input  logic [NUMBER_OF_DEVICES-1:0]              req_valid_i,
    input  logic [NUMBER_OF_DEVICES-1:0]              req_write_i,
    input  logic [NUMBER_OF_DEVICES*ADDRESS_WIDTH-1:0] req_address_i,
    input  logic [NUMBER_OF_DEVICES*DATA_WIDTH-1:0]   req_data_i,
    output logic [NUMBER_OF_DEVICES-1:0]              grant_o,
    output logic [NUMBER_OF_DEVICES-1:0]              req_done_o,
    output logic [DATA_WIDTH-1:0]                     req_data_out_o,
    output logic                                      shared_in_o,
    output logic                                      snoop_valid_o,
    output logic [ADDRESS_WIDTH-1:0]                  snoop_address_o,
    output logic                                      snoop_write_o,
    output logic [NUMBER_OF_DEVICES-1:0]              snoop_source_o,
    input  logic [NUMBER_OF_DEVICES-1:0]              snoop_ack_i,
    input  logic [NUMBER_OF_DEVICES-1:0]              snoop_shared_i,
    input  logic [NUMBER_OF_DEVICES-1:0]              snoop_supply_i,
    input  logic [NUMBER_OF_DEVICES-1:0]              snoop_dirty_i,
    input  logic [NUMBER_OF_DEVICES*DATA_WIDTH-1:0]   snoop_data_i,
    output logic [ADDRESS_WIDTH-1:0]                  ram_address_o,
    output logic                                      ram_read_o,
    output logic                                      ram_write_o,
    output logic [DATA_WIDTH-1:0]                     ram_data_out_o,
    input  logic [DATA_WIDTH-1:0]                     ram_data_in_i,
    input  logic                                      ram_done_i,
    output logic                                      busy_o,
    output logic                                      protocol_error_o
);

    localparam int c_IDX_W = $clog2(NUMBER_OF_DEVICES);
    localparam int c_CNT_W = (SNOOP_TIMEOUT > 1) ? $clog2(SNOOP_TIMEOUT) : 1;
    localparam logic [NUMBER_OF_DEVICES-1:0] c_ONE = {{(NUMBER_OF_DEVICES-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SNOOP     = 3'd1,
        S_RAM_READ  = 3'd2,
        S_RAM_WB    = 3'd3,
        S_RAM_WRITE = 3'd4,
        S_RESPOND   = 3'd5
    } state_t;

    state_t                       state_q, state_d;
    logic [c_IDX_W-1:0]           owner_q, owner_d, ptr_q, ptr_d, sup_idx_q, sup_idx_d;
    logic [ADDRESS_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        wdata_q, wdata_d, sdata_q, sdata_d, rdata_q, rdata_d;
    logic                         write_q, write_d, shared_q, shared_d, dirty_q, dirty_d;
    logic                         sup_found_q, sup_found_d, perr_q, perr_d;
    logic [NUMBER_OF_DEVICES-1:0] ack_q, ack_d, supmask_q, supmask_d;
    logic [c_CNT_W-1:0]           cnt_q, cnt_d;

    logic [NUMBER_OF_DEVICES-1:0] w_owner_oh, w_resp, w_ack_n, w_supmask_n, w_supmask_m1;
    logic                         w_win_valid, w_all_acked, w_timeout;
    logic [c_IDX_W-1:0]           w_win_idx, w_rr_idx;

    assign w_owner_oh   = c_ONE << owner_q;
    assign w_resp       = snoop_ack_i & ~w_owner_oh;
    assign w_ack_n      = ack_q | w_resp;
    assign w_supmask_n  = supmask_q | (w_resp & snoop_supply_i);
    assign w_supmask_m1 = w_supmask_n - c_ONE;
    assign w_all_acked  = &(w_ack_n | w_owner_oh);
    assign w_timeout    = (cnt_q == c_CNT_W'(SNOOP_TIMEOUT - 1));

    // Arbitration; descending loops so the last hit (lowest rank) wins.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_rr_idx    = '0;
        if (ARBITRATION_MODE == 0) begin
            for (int i = NUMBER_OF_DEVICES - 1; i >= 0; i--) begin
                if (req_valid_i[i]) begin
                    w_win_valid = 1'b1;
                    w_win_idx   = c_IDX_W'(i);
                end
            end
        end else begin
            for (int k = NUMBER_OF_DEVICES - 1; k >= 0; k--) begin
                w_rr_idx = c_IDX_W'((int'(ptr_q) + k) % NUMBER_OF_DEVICES);
                if (req_valid_i[w_rr_idx]) begin
                    w_win_valid = 1'b1;
                    w_win_idx   = w_rr_idx;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        ack_d       = ack_q;
        shared_d    = shared_q;
        supmask_d   = supmask_q;
        dirty_d     = dirty_q;
        sup_found_d = sup_found_q;
        sup_idx_d   = sup_idx_q;
        sdata_d     = sdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        perr_d      = perr_q;

        case (state_q)
            S_IDLE: begin
                if (w_win_valid) begin
                    owner_d = w_win_idx;
                    for (int i = 0; i < NUMBER_OF_DEVICES; i++) begin
                        if (w_win_idx == c_IDX_W'(i)) begin
                            addr_d  = req_address_i[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                            wdata_d = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                            write_d = req_write_i[i];
                        end
                    end
                    ack_d       = '0;
                    shared_d    = 1'b0;
                    supmask_d   = '0;
                    dirty_d     = 1'b0;
                    sup_found_d = 1'b0;
                    sup_idx_d   = '0;
                    sdata_d     = '0;
                    rdata_d     = '0;
                    cnt_d       = '0;
                    state_d     = S_SNOOP;
                end
            end
            S_SNOOP: begin
                ack_d     = w_ack_n;
                shared_d  = shared_q | (|(w_resp & snoop_shared_i));
                dirty_d   = dirty_q | (|(w_resp & snoop_dirty_i));
                supmask_d = w_supmask_n;
                cnt_d     = cnt_q + 1'b1;
                for (int i = NUMBER_OF_DEVICES - 1; i >= 0; i--) begin
                    if (w_resp[i] && snoop_supply_i[i] &&
                        (!sup_found_q || (c_IDX_W'(i) < sup_idx_q))) begin
                        sup_found_d = 1'b1;
                        sup_idx_d   = c_IDX_W'(i);
                        sdata_d     = snoop_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (|(w_supmask_n & w_supmask_m1)) begin
                    perr_d = 1'b1;
                end
                if (w_all_acked || w_timeout) begin
                    if (!w_all_acked) begin
                        perr_d = 1'b1;
                    end
                    if (write_q) begin
                        state_d = S_RAM_WRITE;
                    end else if (sup_found_d) begin
                        rdata_d = sdata_d;
                        state_d = dirty_d ? S_RAM_WB : S_RESPOND;
                    end else begin
                        state_d = S_RAM_READ;
                    end
                end
            end
            S_RAM_READ: begin
                if (ram_done_i) begin
                    rdata_d = ram_data_in_i;
                    state_d = S_RESPOND;
                end
            end
            S_RAM_WB, S_RAM_WRITE: begin
                if (ram_done_i) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                ptr_d   = (owner_q == c_IDX_W'(NUMBER_OF_DEVICES - 1)) ? '0 : owner_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            ack_q       <= '0;
            shared_q    <= 1'b0;
            supmask_q   <= '0;
            dirty_q     <= 1'b0;
            sup_found_q <= 1'b0;
            sup_idx_q   <= '0;
            sdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            ack_q       <= ack_d;
            shared_q    <= shared_d;
            supmask_q   <= supmask_d;
            dirty_q     <= dirty_d;
            sup_found_q <= sup_found_d;
            sup_idx_q   <= sup_idx_d;
            sdata_q     <= sdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            perr_q      <= perr_d;
        end
    end

    // Every output is decoded from registered state, so nothing is glitchy or combinational from inputs.
    assign busy_o           = (state_q != S_IDLE);
    assign grant_o          = busy_o ? w_owner_oh : '0;
    assign snoop_valid_o    = (state_q == S_SNOOP);
    assign snoop_address_o  = snoop_valid_o ? addr_q : '0;
    assign snoop_write_o    = snoop_valid_o & write_q;
    assign snoop_source_o   = snoop_valid_o ? w_owner_oh : '0;
    assign ram_read_o       = (state_q == S_RAM_READ);
    assign ram_write_o      = (state_q == S_RAM_WB) || (state_q == S_RAM_WRITE);
    assign ram_address_o    = (ram_read_o || ram_write_o) ? addr_q : '0;
    assign ram_data_out_o   = (state_q == S_RAM_WB)    ? sdata_q :
                              (state_q == S_RAM_WRITE) ? wdata_q : '0;
    assign req_done_o       = (state_q == S_RESPOND) ? w_owner_oh : '0;
    assign req_data_out_o   = (state_q == S_RESPOND) ? rdata_q : '0;
    assign shared_in_o      = (state_q == S_RESPOND) & shared_q;
    assign protocol_error_o = perr_q;

endmodule

`default_nettype wire
